// File: rtl/axi_err_responder.sv
// axi_err_responder: a terminating AXI4 slave. It accepts every request and
// completes it with a fixed error response. Write data is drained and dropped.
// Read bursts return a constant data word. No address is decoded.

package axi_err_responder_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [0:0]  user;
  } aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [0:0]  user;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

module axi_err_responder #(
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiDataWidth = 64,
  parameter logic [1:0]  RespCode     = 2'b10,
  parameter logic [63:0] RespData     = 64'hCA11AB1E_BADCAB1E,
  parameter int unsigned MaxTrans     = 4,
  parameter type         req_t        = axi_err_responder_pkg::req_t,
  parameter type         resp_t       = axi_err_responder_pkg::resp_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o
);

  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  typedef logic [PtrW-1:0]       ptr_t;
  typedef logic [CntW-1:0]       cnt_t;
  typedef logic [AxiIdWidth-1:0] id_t;

  localparam cnt_t Full    = cnt_t'(MaxTrans);
  localparam cnt_t One     = cnt_t'(1);
  localparam ptr_t LastPtr = ptr_t'(MaxTrans - 1);
  localparam logic [AxiDataWidth-1:0] RData = AxiDataWidth'(RespData);

  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_BRESP} w_state_e;
  typedef enum logic       {R_IDLE, R_SEND}           r_state_e;

  // AW id FIFO
  id_t  aw_mem_q [MaxTrans];
  id_t  aw_mem_d [MaxTrans];
  ptr_t aw_wptr_q, aw_wptr_d, aw_rptr_q, aw_rptr_d;
  cnt_t aw_cnt_q, aw_cnt_d;
  logic aw_full, aw_empty, aw_push, aw_pop;

  // AR (id, len) FIFO
  id_t        ar_id_mem_q  [MaxTrans];
  id_t        ar_id_mem_d  [MaxTrans];
  logic [7:0] ar_len_mem_q [MaxTrans];
  logic [7:0] ar_len_mem_d [MaxTrans];
  ptr_t ar_wptr_q, ar_wptr_d, ar_rptr_q, ar_rptr_d;
  cnt_t ar_cnt_q, ar_cnt_d;
  logic ar_full, ar_empty, ar_push, ar_pop;

  w_state_e   w_state_q, w_state_d;
  r_state_e   r_state_q, r_state_d;
  logic [7:0] beat_q, beat_d;

  logic w_ready, b_valid, r_valid, r_last;

  // Request fields outside the handshake/id/len set (addr, atop, data, ...) are ignored.
  logic unused_req;
  assign unused_req = ^slv_req_i;

  // FIFO bookkeeping for both directions; push only when not full.
  always_comb begin
    aw_full   = (aw_cnt_q == Full);
    aw_empty  = (aw_cnt_q == '0);
    aw_push   = slv_req_i.aw_valid && !aw_full;
    aw_mem_d  = aw_mem_q;
    aw_wptr_d = aw_wptr_q;
    aw_rptr_d = aw_rptr_q;
    if (aw_push) begin
      aw_mem_d[aw_wptr_q] = id_t'(slv_req_i.aw.id);
      aw_wptr_d = (aw_wptr_q == LastPtr) ? '0 : aw_wptr_q + 1'b1;
    end
    if (aw_pop) begin
      aw_rptr_d = (aw_rptr_q == LastPtr) ? '0 : aw_rptr_q + 1'b1;
    end
    aw_cnt_d = aw_cnt_q + cnt_t'(aw_push) - cnt_t'(aw_pop);

    ar_full      = (ar_cnt_q == Full);
    ar_empty     = (ar_cnt_q == '0);
    ar_push      = slv_req_i.ar_valid && !ar_full;
    ar_id_mem_d  = ar_id_mem_q;
    ar_len_mem_d = ar_len_mem_q;
    ar_wptr_d    = ar_wptr_q;
    ar_rptr_d    = ar_rptr_q;
    if (ar_push) begin
      ar_id_mem_d[ar_wptr_q]  = id_t'(slv_req_i.ar.id);
      ar_len_mem_d[ar_wptr_q] = slv_req_i.ar.len;
      ar_wptr_d = (ar_wptr_q == LastPtr) ? '0 : ar_wptr_q + 1'b1;
    end
    if (ar_pop) begin
      ar_rptr_d = (ar_rptr_q == LastPtr) ? '0 : ar_rptr_q + 1'b1;
    end
    ar_cnt_d = ar_cnt_q + cnt_t'(ar_push) - cnt_t'(ar_pop);
  end

  // Write FSM: drain W beats up to last, then hold B until accepted.
  // A same-cycle AW push counts toward "FIFO non-empty" so the FSM leaves
  // idle (or skips idle after a pop) without a bubble cycle.
  always_comb begin
    w_state_d = w_state_q;
    aw_pop    = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (!aw_empty || aw_push) w_state_d = W_DRAIN;
      end
      W_DRAIN: begin
        w_ready = 1'b1;
        if (slv_req_i.w_valid && slv_req_i.w.last) w_state_d = W_BRESP;
      end
      W_BRESP: begin
        b_valid = 1'b1;
        if (slv_req_i.b_ready) begin
          aw_pop    = 1'b1;
          w_state_d = ((aw_cnt_q > One) || aw_push) ? W_DRAIN : W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM: stream len+1 beats for the head AR, then move to the next one.
  always_comb begin
    r_state_d = r_state_q;
    beat_d    = beat_q;
    ar_pop    = 1'b0;
    r_valid   = 1'b0;
    r_last    = (beat_q == ar_len_mem_q[ar_rptr_q]);
    unique case (r_state_q)
      R_IDLE: begin
        if (!ar_empty || ar_push) begin
          r_state_d = R_SEND;
          beat_d    = '0;
        end
      end
      R_SEND: begin
        r_valid = 1'b1;
        if (slv_req_i.r_ready) begin
          if (r_last) begin
            ar_pop    = 1'b1;
            beat_d    = '0;
            r_state_d = ((ar_cnt_q > One) || ar_push) ? R_SEND : R_IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Response assembly; user fields stay zero.
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = !aw_full;
    slv_resp_o.ar_ready = !ar_full;
    slv_resp_o.w_ready  = w_ready;
    slv_resp_o.b_valid  = b_valid;
    slv_resp_o.b.id     = aw_mem_q[aw_rptr_q];
    slv_resp_o.b.resp   = RespCode;
    slv_resp_o.r_valid  = r_valid;
    slv_resp_o.r.id     = ar_id_mem_q[ar_rptr_q];
    slv_resp_o.r.data   = RData;
    slv_resp_o.r.resp   = RespCode;
    slv_resp_o.r.last   = r_valid && r_last;
  end

  // State registers; reset discards every outstanding transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_mem_q     <= '{default: '0};
      aw_wptr_q    <= '0;
      aw_rptr_q    <= '0;
      aw_cnt_q     <= '0;
      ar_id_mem_q  <= '{default: '0};
      ar_len_mem_q <= '{default: '0};
      ar_wptr_q    <= '0;
      ar_rptr_q    <= '0;
      ar_cnt_q     <= '0;
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      beat_q       <= '0;
    end else begin
      aw_mem_q     <= aw_mem_d;
      aw_wptr_q    <= aw_wptr_d;
      aw_rptr_q    <= aw_rptr_d;
      aw_cnt_q     <= aw_cnt_d;
      ar_id_mem_q  <= ar_id_mem_d;
      ar_len_mem_q <= ar_len_mem_d;
      ar_wptr_q    <= ar_wptr_d;
      ar_rptr_q    <= ar_rptr_d;
      ar_cnt_q     <= ar_cnt_d;
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      beat_q       <= beat_d;
    end
  end

endmodule

// File: tb/tb_axi_err_responder.sv
// Self-checking bench for axi_err_responder: expected B ids and R beats are
// queued when requests are accepted and checked as responses appear.
module tb_axi_err_responder;
  import axi_err_responder_pkg::*;

  localparam logic [63:0] RDATA = 64'hCA11AB1E_BADCAB1E;
  localparam logic [1:0]  RESP  = 2'b10;

  typedef struct {
    logic [3:0] id;
    logic       last;
  } rexp_t;

  logic  clk = 1'b0;
  logic  rst_n;
  req_t  req;
  resp_t resp;

  int unsigned n_cmp;
  int unsigned n_err;

  rexp_t      exp_r_q[$];
  logic [3:0] exp_b_q[$];
  logic       w_last_q[$];

  axi_err_responder #(
    .AxiIdWidth  (4),
    .AxiDataWidth(64),
    .RespCode    (RESP),
    .RespData    (RDATA),
    .MaxTrans    (4),
    .req_t       (req_t),
    .resp_t      (resp_t)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .slv_req_i (req),
    .slv_resp_o(resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_read(input logic [3:0] id, input logic [7:0] len);
    for (int unsigned i = 0; i <= 32'(len); i++) exp_r_q.push_back('{id: id, last: (i == 32'(len))});
  endtask

  task automatic test_reset();
    req   = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid} !== 5'b11000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required %b",
               {resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid}, 5'b11000);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid} !== 5'b11000) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b required %b",
               {resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid}, 5'b11000);
    end
  endtask

  task automatic test_write_basic();
    logic [3:0] e;
    req.b_ready  = 1'b1;
    req.w_valid  = 1'b1;
    req.w.last   = 1'b0;
    repeat (2) begin
      n_cmp++;
      if (resp.w_ready !== 1'b0) begin
        n_err++;
        $display("FAIL w_stall_before_aw: got %b required 0", resp.w_ready);
      end
      tick();
    end
    req.w_valid  = 1'b0;
    req.aw_valid = 1'b1;
    req.aw.id    = 4'd3;
    n_cmp++;
    if ({resp.aw_ready, resp.w_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL aw_cycle_ready: got aw_ready,w_ready=%b required 10", {resp.aw_ready, resp.w_ready});
    end
    tick();
    req.aw_valid = 1'b0;
    exp_b_q.push_back(4'd3);
    n_cmp++;
    if (resp.w_ready !== 1'b1) begin
      n_err++;
      $display("FAIL w_ready_after_aw: got %b required 1", resp.w_ready);
    end
    for (int i = 0; i < 4; i++) begin
      req.w_valid = 1'b1;
      req.w.last  = (i == 3);
      req.w.data  = {$urandom, $urandom};
      n_cmp++;
      if ({resp.w_ready, resp.b_valid} !== 2'b10) begin
        n_err++;
        $display("FAIL w_drain_beat%0d: got w_ready,b_valid=%b required 10", i, {resp.w_ready, resp.b_valid});
      end
      tick();
    end
    req.w_valid = 1'b0;
    req.w.last  = 1'b0;
    e = exp_b_q.pop_front();
    n_cmp++;
    if ({resp.b_valid, resp.w_ready, resp.b.id, resp.b.resp, resp.b.user} !== {1'b1, 1'b0, e, RESP, 1'b0}) begin
      n_err++;
      $display("FAIL b_after_last_w: got valid=%b wr=%b id=%0h resp=%b user=%b required valid=1 wr=0 id=%0h resp=%b user=0",
               resp.b_valid, resp.w_ready, resp.b.id, resp.b.resp, resp.b.user, e, RESP);
    end
    tick();
    n_cmp++;
    if (resp.b_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b_valid_after_hs: got %b required 0", resp.b_valid);
    end
  endtask

  task automatic test_read_basic();
    rexp_t       e;
    int unsigned beats = 0;
    req.r_ready  = 1'b1;
    req.ar_valid = 1'b1;
    req.ar.id    = 4'd5;
    req.ar.len   = 8'd3;
    n_cmp++;
    if (resp.r_valid !== 1'b0) begin
      n_err++;
      $display("FAIL r_valid_during_ar: got %b required 0", resp.r_valid);
    end
    tick();
    req.ar_valid = 1'b0;
    exp_read(4'd5, 8'd3);
    n_cmp++;
    if (resp.r_valid !== 1'b1) begin
      n_err++;
      $display("FAIL r_first_latency: got %b required 1", resp.r_valid);
    end
    for (int c = 0; c < 20 && exp_r_q.size() != 0; c++) begin
      if (resp.r_valid) begin
        e = exp_r_q.pop_front();
        beats++;
        n_cmp++;
        if ({resp.r.id, resp.r.data, resp.r.resp, resp.r.last, resp.r.user} !== {e.id, RDATA, RESP, e.last, 1'b0}) begin
          n_err++;
          $display("FAIL read_beat%0d: got %h required %h", beats,
                   {resp.r.id, resp.r.data, resp.r.resp, resp.r.last, resp.r.user}, {e.id, RDATA, RESP, e.last, 1'b0});
        end
      end
      tick();
    end
    n_cmp++;
    if (beats != 4 || resp.r_valid !== 1'b0) begin
      n_err++;
      $display("FAIL read_beat_count: got %0d beats (r_valid=%b) required 4 beats (r_valid=0)", beats, resp.r_valid);
    end
  endtask

  task automatic test_back_to_back();
    rexp_t       e;
    int unsigned beats = 0;
    logic        accepted = 1'b0;
    req.r_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req.ar_valid = 1'b1;
      req.ar.id    = 4'(k + 1);
      req.ar.len   = 8'd1;
      n_cmp++;
      if (resp.ar_ready !== 1'b1) begin
        n_err++;
        $display("FAIL ar_ready_slot%0d: got %b required 1", k, resp.ar_ready);
      end
      tick();
      exp_read(4'(k + 1), 8'd1);
    end
    req.ar.id  = 4'd5;
    req.ar.len = 8'd1;
    repeat (2) begin
      n_cmp++;
      if (resp.ar_ready !== 1'b0) begin
        n_err++;
        $display("FAIL ar_ready_full: got %b required 0", resp.ar_ready);
      end
      tick();
    end
    req.r_ready = 1'b1;
    for (int c = 0; c < 60 && (exp_r_q.size() != 0 || !accepted); c++) begin
      if (!accepted && resp.ar_ready) begin
        accepted = 1'b1;
        exp_read(4'd5, 8'd1);
        n_cmp++;
        if (beats != 2) begin
          n_err++;
          $display("FAIL fifth_ar_accept_point: got after %0d beats required after 2", beats);
        end
      end
      if (resp.r_valid) begin
        if (exp_r_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL b2b_unexpected_r: got id=%0h required no beat", resp.r.id);
        end else begin
          e = exp_r_q.pop_front();
          beats++;
          n_cmp++;
          if ({resp.r.id, resp.r.last} !== {e.id, e.last}) begin
            n_err++;
            $display("FAIL b2b_order beat%0d: got id=%0h last=%b required id=%0h last=%b",
                     beats, resp.r.id, resp.r.last, e.id, e.last);
          end
        end
      end
      tick();
      if (accepted) req.ar_valid = 1'b0;
    end
    req.ar_valid = 1'b0;
    n_cmp++;
    if (!accepted || beats != 10 || exp_r_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_total: got accepted=%b beats=%0d left=%0d required accepted=1 beats=10 left=0",
               accepted, beats, exp_r_q.size());
      exp_r_q.delete();
    end
  endtask

  task automatic test_random_backpressure();
    rexp_t       e;
    logic [3:0]  eb;
    r_chan_t     prev_r;
    b_chan_t     prev_b;
    logic        r_stall = 1'b0, b_stall = 1'b0;
    logic        ar_hs, aw_hs, w_hs, done = 1'b0;
    int unsigned rd_sent = 0, wr_sent = 0, total = 0, beats = 0, nb;
    for (int c = 0; c < 3000 && !done; c++) begin
      req.r_ready = 1'($urandom_range(0, 1));
      req.b_ready = 1'($urandom_range(0, 1));
      if (!req.ar_valid && rd_sent < 6 && $urandom_range(0, 1) == 1) begin
        req.ar_valid = 1'b1;
        req.ar.id    = 4'(rd_sent);
        req.ar.len   = 8'($urandom_range(0, 7));
      end
      if (!req.aw_valid && wr_sent < 5 && $urandom_range(0, 1) == 1) begin
        req.aw_valid = 1'b1;
        req.aw.id    = 4'(8 + wr_sent);
        req.aw.atop  = (wr_sent == 2) ? 6'h20 : 6'h00;
      end
      if (!req.w_valid && w_last_q.size() != 0 && $urandom_range(0, 1) == 1) begin
        req.w_valid = 1'b1;
        req.w.last  = w_last_q.pop_front();
        req.w.data  = {$urandom, $urandom};
      end
      if (r_stall) begin
        n_cmp++;
        if ({resp.r_valid, resp.r} !== {1'b1, prev_r}) begin
          n_err++;
          $display("FAIL r_stable: got %b/%h required 1/%h", resp.r_valid, resp.r, prev_r);
        end
      end
      if (b_stall) begin
        n_cmp++;
        if ({resp.b_valid, resp.b} !== {1'b1, prev_b}) begin
          n_err++;
          $display("FAIL b_stable: got %b/%h required 1/%h", resp.b_valid, resp.b, prev_b);
        end
      end
      if (resp.r_valid && req.r_ready) begin
        beats++;
        if (exp_r_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rnd_unexpected_r: got id=%0h required no beat", resp.r.id);
        end else begin
          e = exp_r_q.pop_front();
          n_cmp++;
          if ({resp.r.id, resp.r.data, resp.r.resp, resp.r.last, resp.r.user} !== {e.id, RDATA, RESP, e.last, 1'b0}) begin
            n_err++;
            $display("FAIL rnd_r_beat: got %h required %h",
                     {resp.r.id, resp.r.data, resp.r.resp, resp.r.last, resp.r.user}, {e.id, RDATA, RESP, e.last, 1'b0});
          end
        end
      end
      if (resp.b_valid && req.b_ready) begin
        if (exp_b_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rnd_unexpected_b: got id=%0h required no response", resp.b.id);
        end else begin
          eb = exp_b_q.pop_front();
          n_cmp++;
          if ({resp.b.id, resp.b.resp, resp.b.user} !== {eb, RESP, 1'b0}) begin
            n_err++;
            $display("FAIL rnd_b: got id=%0h resp=%b user=%b required id=%0h resp=%b user=0",
                     resp.b.id, resp.b.resp, resp.b.user, eb, RESP);
          end
        end
      end
      r_stall = resp.r_valid && !req.r_ready;
      b_stall = resp.b_valid && !req.b_ready;
      prev_r  = resp.r;
      prev_b  = resp.b;
      ar_hs   = req.ar_valid && resp.ar_ready;
      aw_hs   = req.aw_valid && resp.aw_ready;
      w_hs    = req.w_valid && resp.w_ready;
      if (ar_hs) begin
        exp_read(req.ar.id, req.ar.len);
        total += 32'(req.ar.len) + 1;
        rd_sent++;
      end
      if (aw_hs) begin
        exp_b_q.push_back(req.aw.id);
        nb = $urandom_range(1, 4);
        for (int unsigned i = 1; i <= nb; i++) w_last_q.push_back(i == nb);
        wr_sent++;
      end
      tick();
      if (ar_hs) req.ar_valid = 1'b0;
      if (aw_hs) req.aw_valid = 1'b0;
      if (w_hs)  req.w_valid  = 1'b0;
      done = (rd_sent == 6) && (wr_sent == 5) && (exp_r_q.size() == 0) && (exp_b_q.size() == 0)
             && (w_last_q.size() == 0) && !req.w_valid;
    end
    req.r_ready = 1'b1;
    req.b_ready = 1'b1;
    req.aw.atop = 6'h00;
    n_cmp++;
    if (!done || beats != total) begin
      n_err++;
      $display("FAIL rnd_total_beats: got done=%b beats=%0d required done=1 beats=%0d", done, beats, total);
      exp_r_q.delete();
      exp_b_q.delete();
      w_last_q.delete();
    end
    tick();
    n_cmp++;
    if ({resp.r_valid, resp.b_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL rnd_quiet_after: got r_valid,b_valid=%b required 00", {resp.r_valid, resp.b_valid});
    end
  endtask

  task automatic test_long_burst();
    logic [3:0]  eb;
    logic        aw_hs, w_hs;
    int unsigned beats = 0, b_seen = 0, wr_left = 3, b_done_beat = 999;
    req.r_ready  = 1'b1;
    req.b_ready  = 1'b1;
    req.ar_valid = 1'b1;
    req.ar.id    = 4'd7;
    req.ar.len   = 8'd255;
    tick();
    req.ar_valid = 1'b0;
    for (int c = 0; c < 700 && !(beats >= 256 && b_seen == 3); c++) begin
      if (!req.aw_valid && wr_left > 0) begin
        req.aw_valid = 1'b1;
        req.aw.id    = 4'(wr_left);
      end
      if (!req.w_valid && w_last_q.size() != 0) begin
        req.w_valid = 1'b1;
        req.w.last  = w_last_q.pop_front();
      end
      if (resp.r_valid) begin
        n_cmp++;
        if ({resp.r.id, resp.r.data, resp.r.last} !== {4'd7, RDATA, beats == 255}) begin
          n_err++;
          $display("FAIL long_beat%0d: got id=%0h data=%h last=%b required id=7 data=%h last=%b",
                   beats, resp.r.id, resp.r.data, resp.r.last, RDATA, beats == 255);
        end
        beats++;
      end
      if (resp.b_valid) begin
        if (exp_b_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL long_unexpected_b: got id=%0h required no response", resp.b.id);
        end else begin
          eb = exp_b_q.pop_front();
          b_seen++;
          if (b_seen == 3) b_done_beat = beats;
          n_cmp++;
          if ({resp.b.id, resp.b.resp} !== {eb, RESP}) begin
            n_err++;
            $display("FAIL long_b: got id=%0h resp=%b required id=%0h resp=%b", resp.b.id, resp.b.resp, eb, RESP);
          end
        end
      end
      aw_hs = req.aw_valid && resp.aw_ready;
      w_hs  = req.w_valid && resp.w_ready;
      if (aw_hs) begin
        exp_b_q.push_back(req.aw.id);
        w_last_q.push_back(1'b0);
        w_last_q.push_back(1'b1);
        wr_left--;
      end
      tick();
      if (aw_hs) req.aw_valid = 1'b0;
      if (w_hs)  req.w_valid  = 1'b0;
    end
    repeat (3) tick();
    n_cmp++;
    if (beats != 256 || resp.r_valid !== 1'b0) begin
      n_err++;
      $display("FAIL long_beat_count: got %0d (r_valid=%b) required 256 (r_valid=0)", beats, resp.r_valid);
    end
    n_cmp++;
    if (b_seen != 3 || b_done_beat >= 256) begin
      n_err++;
      $display("FAIL long_writes_concurrent: got %0d B by beat %0d required 3 B before beat 256", b_seen, b_done_beat);
      exp_b_q.delete();
      w_last_q.delete();
    end
  endtask

  task automatic test_reset_mid_burst();
    req.r_ready  = 1'b1;
    req.ar_valid = 1'b1;
    req.ar.id    = 4'd6;
    req.ar.len   = 8'd7;
    tick();
    req.ar_valid = 1'b0;
    tick();
    n_cmp++;
    if ({resp.r_valid, resp.r.id, resp.r.last} !== {1'b1, 4'd6, 1'b0}) begin
      n_err++;
      $display("FAIL second_beat_present: got valid=%b id=%0h last=%b required valid=1 id=6 last=0",
               resp.r_valid, resp.r.id, resp.r.last);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({resp.r_valid, resp.ar_ready, resp.aw_ready} !== 3'b011) begin
      n_err++;
      $display("FAIL async_reset_r_valid: got r_valid,ar_ready,aw_ready=%b required 011",
               {resp.r_valid, resp.ar_ready, resp.aw_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if ({resp.r_valid, resp.b_valid} !== 2'b00) begin
        n_err++;
        $display("FAIL no_r_after_reset cycle%0d: got r_valid,b_valid=%b required 00", c, {resp.r_valid, resp.b_valid});
      end
      tick();
    end
    req.ar_valid = 1'b1;
    req.ar.id    = 4'd2;
    req.ar.len   = 8'd0;
    tick();
    req.ar_valid = 1'b0;
    n_cmp++;
    if ({resp.r_valid, resp.r.id, resp.r.last} !== {1'b1, 4'd2, 1'b1}) begin
      n_err++;
      $display("FAIL new_ar_after_reset: got valid=%b id=%0h last=%b required valid=1 id=2 last=1",
               resp.r_valid, resp.r.id, resp.r.last);
    end
    tick();
    n_cmp++;
    if (resp.r_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_beat_done: got %b required 0", resp.r_valid);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    req   = '0;
    rst_n = 1'b0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_back_to_back();
    test_random_backpressure();
    test_long_burst();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
